// File: rtl/elevator_pkg.sv
// Shared elevator definitions: geometry, observer FSM states and small helpers.
// Used by the core, the statistics observer and the bench.
package elevator_pkg;

    localparam int FLOORS      = 7;
    localparam int FLOOR_W     = 3;
    localparam int MAP_W       = 6;
    localparam int MAX_PENDING = 54;
    localparam int PEND_W      = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DONE    = 2'd2,
        TIMEOUT = 2'd3
    } stats_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // True when a car moved by more than one floor between two samples.
    function automatic logic floor_jump(input logic [FLOOR_W-1:0] a,
                                        input logic [FLOOR_W-1:0] b);
        return (a > b) ? ((a - b) > 3'd1) : ((b - a) > 3'd1);
    endfunction

endpackage

// File: rtl/elevator_popcount6.sv
// Combinational popcount of one 6-bit passenger bitmap.
module elevator_popcount6
    import elevator_pkg::*;
(
    input  logic [MAP_W-1:0] bits,
    output logic [2:0]       count
);

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < MAP_W; i++) begin
            count = count + {2'b00, bits[i]};
        end
    end

endmodule

// File: rtl/elevator_stats.sv
// Passive observer of the elevator core: run completion, finish time,
// per-car move counts, live pending count and sticky error flags.
module elevator_stats
    import elevator_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 200,
    parameter int unsigned DONE_HOLD      = 2
) (
    input  logic               clock,
    input  logic               reset_start,
    input  logic [7:0]         time_counter,
    input  logic [MAP_W-1:0]   remaining_1,
    input  logic [MAP_W-1:0]   remaining_2,
    input  logic [MAP_W-1:0]   remaining_3,
    input  logic [MAP_W-1:0]   remaining_4,
    input  logic [MAP_W-1:0]   remaining_5,
    input  logic [MAP_W-1:0]   remaining_6,
    input  logic [MAP_W-1:0]   remaining_7,
    input  logic [MAP_W-1:0]   boarding_1,
    input  logic [MAP_W-1:0]   boarding_2,
    input  logic [FLOOR_W-1:0] curr_elevator_1,
    input  logic [FLOOR_W-1:0] curr_elevator_2,
    output logic [PEND_W-1:0]  pending_count,
    output logic               done,
    output logic               timed_out,
    output logic [7:0]         finish_time,
    output logic [7:0]         moves_1,
    output logic [7:0]         moves_2,
    output logic               err_jump,
    output logic               err_range
);

    localparam logic [3:0]  HOLD    = 4'(DONE_HOLD);
    localparam logic [3:0]  HOLD_M1 = 4'(DONE_HOLD - 1);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    stats_state_t       state, state_next;
    logic [MAP_W-1:0]   maps [9];
    logic [2:0]         pc_part [9];
    logic [PEND_W-1:0]  pc;
    logic [3:0]         zero_run;
    logic [15:0]        run_cnt;
    logic [FLOOR_W-1:0] prev_floor_1, prev_floor_2;
    logic               pc_zero, done_cond, timeout_cond;

    assign maps[0] = remaining_1;
    assign maps[1] = remaining_2;
    assign maps[2] = remaining_3;
    assign maps[3] = remaining_4;
    assign maps[4] = remaining_5;
    assign maps[5] = remaining_6;
    assign maps[6] = remaining_7;
    assign maps[7] = boarding_1;
    assign maps[8] = boarding_2;

    for (genvar g = 0; g < 9; g++) begin : g_pc
        elevator_popcount6 u_pc (
            .bits  (maps[g]),
            .count (pc_part[g])
        );
    end

    always_comb begin
        pc = '0;
        for (int unsigned i = 0; i < 9; i++) begin
            pc = pc + {3'b000, pc_part[i]};
        end
    end

    // The current zero cycle counts toward the hold, so compare against HOLD-1.
    assign pc_zero      = (pc == '0);
    assign done_cond    = pc_zero && (zero_run >= HOLD_M1);
    assign timeout_cond = (run_cnt == TO_LAST) && !done_cond;

    always_ff @(posedge clock) begin
        if (reset_start) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = RUN;
            RUN: begin
                if (done_cond) begin
                    state_next = DONE;
                end else if (timeout_cond) begin
                    state_next = TIMEOUT;
                end
            end
            default: state_next = state;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset_start) begin
            pending_count <= '0;
            done          <= 1'b0;
            timed_out     <= 1'b0;
            finish_time   <= '0;
            moves_1       <= '0;
            moves_2       <= '0;
            err_jump      <= 1'b0;
            err_range     <= 1'b0;
            zero_run      <= '0;
            run_cnt       <= '0;
            prev_floor_1  <= '0;
            prev_floor_2  <= '0;
        end else begin
            pending_count <= pc;
            done          <= (state_next == DONE);
            timed_out     <= (state_next == TIMEOUT);
            prev_floor_1  <= curr_elevator_1;
            prev_floor_2  <= curr_elevator_2;

            if (state != IDLE) begin
                if (floor_jump(curr_elevator_1, prev_floor_1) ||
                    floor_jump(curr_elevator_2, prev_floor_2)) begin
                    err_jump <= 1'b1;
                end
                if ((curr_elevator_1 == 3'd7) || (curr_elevator_2 == 3'd7)) begin
                    err_range <= 1'b1;
                end
            end

            if (state == RUN) begin
                run_cnt <= run_cnt + 16'd1;
                if (pc_zero) begin
                    zero_run <= (zero_run == HOLD) ? zero_run : zero_run + 4'd1;
                end else begin
                    zero_run <= '0;
                end
                if (curr_elevator_1 != prev_floor_1) begin
                    moves_1 <= sat_inc8(moves_1);
                end
                if (curr_elevator_2 != prev_floor_2) begin
                    moves_2 <= sat_inc8(moves_2);
                end
                if (done_cond) begin
                    finish_time <= time_counter;
                end
            end
        end
    end

endmodule

// File: tb/tb_elevator_stats.sv
// Randomized and directed bench for elevator_stats, two parameterisations
// checked against a cycle-level behavioural model.
module tb_elevator_stats;
    import elevator_pkg::*;

    localparam int TO_A = 20;
    localparam int DH_A = 2;
    localparam int TO_B = 600;
    localparam int DH_B = 3;

    logic       clock = 1'b0;
    logic       reset_start = 1'b1;
    logic [7:0] time_counter = 8'd0;
    logic [5:0] rem [1:7];
    logic [5:0] brd1, brd2;
    logic [2:0] car1, car2;

    logic [5:0] a_pend, b_pend;
    logic       a_done, a_to, a_ej, a_er, b_done, b_to, b_ej, b_er;
    logic [7:0] a_fin, a_mv1, a_mv2, b_fin, b_mv1, b_mv2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    elevator_stats #(.TIMEOUT_CYCLES(TO_A), .DONE_HOLD(DH_A)) dut_a (
        .clock(clock), .reset_start(reset_start), .time_counter(time_counter),
        .remaining_1(rem[1]), .remaining_2(rem[2]), .remaining_3(rem[3]),
        .remaining_4(rem[4]), .remaining_5(rem[5]), .remaining_6(rem[6]),
        .remaining_7(rem[7]), .boarding_1(brd1), .boarding_2(brd2),
        .curr_elevator_1(car1), .curr_elevator_2(car2),
        .pending_count(a_pend), .done(a_done), .timed_out(a_to),
        .finish_time(a_fin), .moves_1(a_mv1), .moves_2(a_mv2),
        .err_jump(a_ej), .err_range(a_er)
    );

    elevator_stats #(.TIMEOUT_CYCLES(TO_B), .DONE_HOLD(DH_B)) dut_b (
        .clock(clock), .reset_start(reset_start), .time_counter(time_counter),
        .remaining_1(rem[1]), .remaining_2(rem[2]), .remaining_3(rem[3]),
        .remaining_4(rem[4]), .remaining_5(rem[5]), .remaining_6(rem[6]),
        .remaining_7(rem[7]), .boarding_1(brd1), .boarding_2(brd2),
        .curr_elevator_1(car1), .curr_elevator_2(car2),
        .pending_count(b_pend), .done(b_done), .timed_out(b_to),
        .finish_time(b_fin), .moves_1(b_mv1), .moves_2(b_mv2),
        .err_jump(b_ej), .err_range(b_er)
    );

    // Model: phase 0=idle 1=run 2=done 3=timeout; streak/runs are unbounded counts.
    int ph[2], streak[2], runs[2], m_pend[2], m_fin[2], m_mv1[2], m_mv2[2];
    int m_pf1[2], m_pf2[2];
    bit m_ej[2], m_er[2];
    int to_lim[2] = '{TO_A, TO_B};
    int hold[2]   = '{DH_A, DH_B};

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    task automatic model_step();
        int pc;
        pc = $countones(brd1) + $countones(brd2);
        for (int f = 1; f <= 7; f++) pc += $countones(rem[f]);
        for (int i = 0; i < 2; i++) begin
            if (reset_start) begin
                ph[i] = 0; streak[i] = 0; runs[i] = 0; m_pend[i] = 0; m_fin[i] = 0;
                m_mv1[i] = 0; m_mv2[i] = 0; m_pf1[i] = 0; m_pf2[i] = 0;
                m_ej[i] = 0; m_er[i] = 0;
            end else begin
                m_pend[i] = pc;
                if (ph[i] == 0) begin
                    ph[i] = 1;
                end else begin
                    if (car1 == 3'd7 || car2 == 3'd7) m_er[i] = 1;
                    if (iabs(int'(car1) - m_pf1[i]) > 1 || iabs(int'(car2) - m_pf2[i]) > 1)
                        m_ej[i] = 1;
                    if (ph[i] == 1) begin
                        if (int'(car1) != m_pf1[i] && m_mv1[i] < 255) m_mv1[i]++;
                        if (int'(car2) != m_pf2[i] && m_mv2[i] < 255) m_mv2[i]++;
                        streak[i] = (pc == 0) ? streak[i] + 1 : 0;
                        runs[i]++;
                        if (streak[i] >= hold[i]) begin
                            ph[i] = 2;
                            m_fin[i] = int'(time_counter);
                        end else if (runs[i] == to_lim[i]) begin
                            ph[i] = 3;
                        end
                    end
                end
                m_pf1[i] = int'(car1);
                m_pf2[i] = int'(car2);
            end
        end
    endtask

    function automatic logic [33:0] dut_vec(input int i);
        if (i == 0) return {a_pend, a_done, a_to, a_fin, a_mv1, a_mv2, a_ej, a_er};
        return {b_pend, b_done, b_to, b_fin, b_mv1, b_mv2, b_ej, b_er};
    endfunction

    function automatic logic [33:0] mdl_vec(input int i);
        return {6'(m_pend[i]), ph[i] == 2, ph[i] == 3, 8'(m_fin[i]),
                8'(m_mv1[i]), 8'(m_mv2[i]), m_ej[i], m_er[i]};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        time_counter = time_counter + 8'($urandom_range(1, 3));
    endtask

    task automatic clear_inputs();
        for (int f = 1; f <= 7; f++) rem[f] = '0;
        brd1 = '0; brd2 = '0; car1 = '0; car2 = '0;
    endtask

    task automatic do_reset();
        reset_start = 1'b1;
        tick();
        tick();
        reset_start = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rem[2] = 6'b101010; car1 = 3'd3;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (dut_vec(i) !== 34'd0 || dut_vec(i) !== mdl_vec(i)) begin
                n_bad++;
                $display("FAIL reset dut%0d: got %h want %h", i, dut_vec(i), mdl_vec(i));
            end
        end
    endtask

    task automatic test_quick_done();
        logic [7:0] t3;
        clear_inputs();
        do_reset();
        for (int c = 1; c <= 4; c++) begin
            if (c == 3) t3 = time_counter;
            tick();
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (dut_vec(i) !== mdl_vec(i)) begin
                    n_bad++;
                    $display("FAIL quick_done c%0d dut%0d: got %h want %h", c, i, dut_vec(i), mdl_vec(i));
                end
            end
            if (c == 3) begin
                n_cmp++;
                if ({a_done, b_done, a_fin, a_mv1, a_mv2} !== {1'b1, 1'b0, t3, 16'd0}) begin
                    n_bad++;
                    $display("FAIL earliest_done: got %b/%b fin %h want 1/0 fin %h", a_done, b_done, a_fin, t3);
                end
            end
        end
        n_cmp++;
        if (b_done !== 1'b1) begin
            n_bad++;
            $display("FAIL earliest_done_hold3: got %b want 1", b_done);
        end
    endtask

    task automatic test_pending_hold();
        clear_inputs();
        do_reset();
        rem[3] = 6'b000111; brd1 = 6'b100000;
        for (int c = 0; c < 10; c++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (dut_vec(i) !== mdl_vec(i)) begin
                    n_bad++;
                    $display("FAIL pending_hold c%0d dut%0d: got %h want %h", c, i, dut_vec(i), mdl_vec(i));
                end
            end
        end
        n_cmp++;
        if (a_pend !== 6'd4 || a_done !== 1'b0) begin
            n_bad++;
            $display("FAIL pending_four: got %0d done %b want 4 done 0", a_pend, a_done);
        end
        clear_inputs();
        tick();
        tick();
        n_cmp++;
        if (a_done !== 1'b1 || a_pend !== 6'd0) begin
            n_bad++;
            $display("FAIL done_after_clear: got done %b pend %0d want 1 0", a_done, a_pend);
        end
    endtask

    task automatic test_moves();
        logic [2:0] seq [5] = '{3'd1, 3'd2, 3'd3, 3'd2, 3'd2};
        clear_inputs();
        rem[1] = 6'b000001;
        do_reset();
        tick();
        for (int c = 0; c < 5; c++) begin
            car1 = seq[c];
            tick();
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (dut_vec(i) !== mdl_vec(i)) begin
                    n_bad++;
                    $display("FAIL moves c%0d dut%0d: got %h want %h", c, i, dut_vec(i), mdl_vec(i));
                end
            end
        end
        n_cmp++;
        if ({a_mv1, a_mv2, a_ej, a_er} !== {8'd4, 8'd0, 2'b00}) begin
            n_bad++;
            $display("FAIL step_moves: got %0d/%0d err %b%b want 4/0 err 00", a_mv1, a_mv2, a_ej, a_er);
        end
    endtask

    task automatic test_errors();
        logic [2:0] seq [6] = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd6, 3'd6};
        clear_inputs();
        rem[1] = 6'b000001; car2 = 3'd1;
        do_reset();
        tick();
        for (int c = 0; c < 6; c++) begin
            car2 = seq[c];
            if (c == 4) clear_inputs();
            if (c >= 4) car2 = 3'd6;
            tick();
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (dut_vec(i) !== mdl_vec(i)) begin
                    n_bad++;
                    $display("FAIL errors c%0d dut%0d: got %h want %h", c, i, dut_vec(i), mdl_vec(i));
                end
            end
            if (c == 0 || c == 3) begin
                n_cmp++;
                if (a_ej !== 1'b1 || a_er !== (c == 3)) begin
                    n_bad++;
                    $display("FAIL err_flag c%0d: got jump %b range %b", c, a_ej, a_er);
                end
            end
        end
        n_cmp++;
        if ({a_done, a_ej, a_er} !== 3'b111) begin
            n_bad++;
            $display("FAIL err_sticky_done: got %b want 111", {a_done, a_ej, a_er});
        end
    endtask

    task automatic test_timeout();
        logic [7:0] mv;
        clear_inputs();
        rem[5] = 6'b000001;
        do_reset();
        for (int c = 0; c < 1 + TO_A; c++) begin
            car2 = 3'(c % 2);
            tick();
        end
        n_cmp++;
        if ({a_to, a_done, b_to} !== 3'b100) begin
            n_bad++;
            $display("FAIL timeout: got to %b done %b b_to %b want 1 0 0", a_to, a_done, b_to);
        end
        mv = a_mv2;
        car1 = 3'd1;
        tick();
        car1 = 3'd2;
        rem[5] = '0;
        tick();
        n_cmp++;
        if (a_mv1 !== 8'd0 || a_mv2 !== mv || a_to !== 1'b1 || a_pend !== 6'd0) begin
            n_bad++;
            $display("FAIL timeout_frozen: got mv %0d/%0d to %b pend %0d want 0/%0d 1 0", a_mv1, a_mv2, a_to, a_pend, mv);
        end
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (dut_vec(i) !== mdl_vec(i)) begin
                n_bad++;
                $display("FAIL timeout_model dut%0d: got %h want %h", i, dut_vec(i), mdl_vec(i));
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        rem[1] = 6'b000001;
        do_reset();
        tick();
        for (int c = 0; c < 9; c++) begin
            car1 = ~car1 & 3'd1;
            tick();
        end
        n_cmp++;
        if (a_mv1 !== 8'd9) begin
            n_bad++;
            $display("FAIL moves_nine: got %0d want 9", a_mv1);
        end
        reset_start = 1'b1;
        tick();
        reset_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (dut_vec(i) !== 34'd0) begin
                n_bad++;
                $display("FAIL reset_mid dut%0d: got %h want 0", i, dut_vec(i));
            end
        end
        car1 = 3'd3;
        tick();
        car1 = 3'd4;
        tick();
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (dut_vec(i) !== mdl_vec(i)) begin
                n_bad++;
                $display("FAIL resume dut%0d: got %h want %h", i, dut_vec(i), mdl_vec(i));
            end
        end
    endtask

    task automatic test_saturation();
        clear_inputs();
        rem[7] = 6'b110000;
        do_reset();
        for (int c = 0; c < 270; c++) begin
            car1 = ~car1 & 3'd1;
            tick();
        end
        n_cmp++;
        if (b_mv1 !== 8'd255 || b_to !== 1'b0) begin
            n_bad++;
            $display("FAIL moves_sat: got %0d to %b want 255 0", b_mv1, b_to);
        end
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (dut_vec(i) !== mdl_vec(i)) begin
                n_bad++;
                $display("FAIL sat_model dut%0d: got %h want %h", i, dut_vec(i), mdl_vec(i));
            end
        end
    endtask

    task automatic test_random();
        int busy;
        for (int e = 0; e < 10; e++) begin
            clear_inputs();
            car1 = 3'($urandom_range(0, 6));
            car2 = 3'($urandom_range(0, 6));
            do_reset();
            busy = $urandom_range(0, 25);
            for (int c = 0; c < 40; c++) begin
                for (int f = 1; f <= 7; f++)
                    rem[f] = (c < busy && $urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
                brd1 = (c < busy && $urandom_range(0, 1) == 0) ? 6'($urandom) : 6'd0;
                brd2 = (c < busy && $urandom_range(0, 1) == 0) ? 6'($urandom) : 6'd0;
                if ($urandom_range(0, 14) == 0) car1 = 3'($urandom_range(0, 7));
                else if (car1 < 3'd6 && $urandom_range(0, 1) == 0) car1 = car1 + 3'd1;
                else if (car1 > 3'd0 && $urandom_range(0, 1) == 0) car1 = car1 - 3'd1;
                if ($urandom_range(0, 14) == 0) car2 = 3'($urandom_range(0, 7));
                else if (car2 < 3'd6 && $urandom_range(0, 1) == 0) car2 = car2 + 3'd1;
                else if (car2 > 3'd0 && $urandom_range(0, 1) == 0) car2 = car2 - 3'd1;
                reset_start = ($urandom_range(0, 59) == 0);
                tick();
                for (int i = 0; i < 2; i++) begin
                    n_cmp++;
                    if (dut_vec(i) !== mdl_vec(i)) begin
                        n_bad++;
                        $display("FAIL random e%0d c%0d dut%0d: got %h want %h", e, c, i, dut_vec(i), mdl_vec(i));
                    end
                end
            end
            reset_start = 1'b0;
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_quick_done();
        test_pending_hold();
        test_moves();
        test_errors();
        test_timeout();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/elevator_stats.md
# elevator_stats

Downstream observer of the elevator core: samples the registered core outputs (`time_counter`, `remaining_*`, `boarding_*`, `curr_elevator_*`) every cycle. It produces a run-completion flag, the finish timestamp, per-car floor-move counts, a live pending-passenger count and sticky error flags. Results feed the board display and the verification scoreboard. It never drives the core.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 200: RUN cycles before TIMEOUT; range 1..65535.
- `DONE_HOLD`, 2: consecutive zero-pending cycles required to declare DONE; range 1..15.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset_start` in 1: synchronous, active-high reset.
- `time_counter` in 8: core time count.
- `remaining_1`..`remaining_7` in 6 each: waiting-request bitmaps per floor; each set bit is one pending passenger.
- `boarding_1`, `boarding_2` in 6 each: onboard bitmaps per car; each set bit is one passenger.
- `curr_elevator_1`, `curr_elevator_2` in 3 each: car floor; legal values 0..6.
- `pending_count` out 6: registered popcount of all 9 bitmaps; range 0..54.
- `done` out 1: high in DONE state.
- `timed_out` out 1: high in TIMEOUT state.
- `finish_time` out 8: `time_counter` latched on entry to DONE.
- `moves_1`, `moves_2` out 8 each: floor changes per car, saturating at 255.
- `err_jump` out 1: sticky; set when any car changes by more than one floor in one cycle.
- `err_range` out 1: sticky; set when any car reports floor 7.

## Operation
- FSM states: IDLE, RUN, DONE, TIMEOUT. Encoding lives in the package.
- IDLE is entered on reset. The first post-reset cycle captures `prev_floor_k <= curr_elevator_k`. No move is counted in this cycle. The FSM goes to RUN on the next edge unconditionally.
- RUN:
  - Each cycle computes `pc` = sum of popcounts; `pending_count <= pc`.
  - `zero_run` counter: increments while pc==0, clears when pc!=0, saturates at DONE_HOLD.
  - `run_cnt` (16 bit) increments each RUN cycle.
  - Move detection: if `curr_elevator_k != prev_floor_k`, then `moves_k <= sat(moves_k+1)`. If |diff| > 1, set `err_jump`. `prev_floor_k` updates every cycle.
  - Range check: if `curr_elevator_k == 7`, set `err_range`. A floor-7 value still updates prev/moves under the same rules.
- RUN to DONE: when `zero_run` reaches DONE_HOLD, i.e. pc==0 for DONE_HOLD consecutive RUN cycles including the current one. On this transition, `finish_time <= time_counter` of the current cycle.
- RUN to TIMEOUT: when `run_cnt == TIMEOUT_CYCLES-1` and the DONE condition is false.
- If DONE and TIMEOUT conditions occur in the same cycle, DONE wins.
- DONE and TIMEOUT are terminal until `reset_start`. In both states:
  - Counters, `moves_*` and `finish_time` are frozen.
  - `pending_count` keeps updating.
  - Error flags keep accumulating.
- Reset asserted in any state: on the next edge, all outputs and internal registers clear and the FSM returns to IDLE. Reset overrides all other updates.

## Timing
- All outputs are registered. Reset value of every output is 0.
- `pending_count` reflects inputs sampled at the previous edge: 1-cycle latency.
- `moves_k`, `err_*`: updated at the edge following the input change: 1-cycle latency.
- `done`: rises at the edge after the DONE_HOLD-th consecutive zero cycle. `finish_time` is valid in the same cycle `done` first reads 1.
- Earliest `done`: edge 2 + DONE_HOLD - 1 after reset deasserts (one IDLE cycle + DONE_HOLD RUN cycles), given pending inputs are zero.
- Saturation: `moves_k` holds at 255; `zero_run` holds at DONE_HOLD; `run_cnt` stops in terminal states.

## Structure
- Shared package `elevator_pkg`, also used by the core and bench:
  - `FLOORS=7`, `FLOOR_W=3`, `MAP_W=6`
  - `stats_state_t` (IDLE/RUN/DONE/TIMEOUT)
  - `MAX_PENDING=54`
- Sub-module `elevator_popcount6`: combinational 6-bit to 3-bit popcount, instantiated 9 times. The top sums the nine results into 6 bits.
- Everything else (FSM, counters, per-car move trackers) lives in the top file.

## Test plan
- Reset, all bitmaps 0, cars static at floor 0 → `done`=1 at cycle 3 after reset release (DONE_HOLD=2); `finish_time` = `time_counter` of cycle 2; `moves_*`=0.
- `remaining_3`=6'b000111 and `boarding_1`=6'b100000 for 10 cycles, then all 0 → `pending_count`=4 during hold; `done` rises 2 cycles after clearing.
- Car 1 stepping 0→1→2→3→2, car 2 static → `moves_1`=4, `moves_2`=0, no errors.
- Car 2 jumps 1→4, later shows 7 → `err_jump`=1 the following cycle, `err_range`=1 the following cycle; both stay high through a later DONE.
- TIMEOUT_CYCLES=20, `remaining_5`=6'b000001 held → `timed_out`=1 after 20 RUN cycles; `done` stays 0; `moves_*` frozen afterward.
- `reset_start` pulsed mid-RUN with `moves_1`=9 → next edge all outputs 0, FSM in IDLE; RUN resumes one cycle after reset drops.
